systolic_array_acc: RTL and testbench

//  Parametrised weight-stationary systolic MAC array, N_ROWS x N_COLS, with per-column output accumulation.

---
 rtl/systolic_array_acc.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_systolic_array_acc.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_acc.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_acc
// Purpose  : Weight-stationary N_ROWS x N_COLS signed MAC array with
//            per-column run-length accumulation. Computes
//            y[c] = sum_k sum_r w[r][c] * x_k[r]. Input skew and output
//            deskew are internal; results are held under backpressure.
// Ports    : clk, rst (async, active-high)
//            cfg_valid/cfg_ready/cfg_weight : weight column load, first beat
//                                             lands in column N_COLS-1
//            start/len                      : run request (IDLE only)
//            feat_valid/feat_ready/feat_data: feature vectors during RUN
//            out_valid/out_ready/out_data   : result vector, lane c = y[c]
//            busy                           : not IDLE
//            ovf                            : sticky saturation flag
// Config   : SYSTOLIC_ACC_SAT_EN - saturating accumulation with ovf flag;
//            undefined: wrapping accumulation, ovf tied low.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_acc #(
    parameter int N_ROWS  = 3,
    parameter int N_COLS  = 4,
    parameter int I_WIDTH = 16,
    parameter int O_WIDTH = 40,
    parameter int LEN_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [N_ROWS*I_WIDTH-1:0]  cfg_weight,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [N_ROWS*I_WIDTH-1:0]  feat_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_COLS*O_WIDTH-1:0]  out_data,
    output logic                       busy,
    output logic                       ovf
);

    localparam int C_BEAT_W  = $clog2(N_COLS + 1);
    localparam int C_DRAIN   = N_ROWS + N_COLS;
    localparam int C_DRAIN_W = $clog2(C_DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [C_BEAT_W-1:0]    r_beat_cnt;
    logic [LEN_W-1:0]       r_len_left;
    logic [C_DRAIN_W-1:0]   r_drain_cnt;
    logic                   w_cfg_fire, w_feat_fire, w_run_enter;

    logic signed [I_WIDTH-1:0] r_w [N_ROWS][N_COLS];

    assign w_cfg_fire  = cfg_valid & cfg_ready;
    assign w_feat_fire = feat_valid & feat_ready;
    assign w_run_enter = (r_state == S_IDLE) && (w_state_nxt == S_RUN);

    // ---------------- control FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        feat_ready  = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                // A weight beat takes precedence over a simultaneous start.
                if (cfg_valid)
                    w_state_nxt = (N_COLS == 1) ? S_IDLE : S_LOAD;
                else if (start && (len != '0))
                    w_state_nxt = S_RUN;
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (r_beat_cnt == C_BEAT_W'(N_COLS - 1)))
                    w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                feat_ready = 1'b1;
                if (feat_valid && (r_len_left == LEN_W'(1)))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leaves exactly N_ROWS+N_COLS edges after the last feature,
                // the edge at which the final wavefront is accumulated.
                if (r_drain_cnt == C_DRAIN_W'(C_DRAIN - 1))
                    w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_len_left  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_fire)
                r_beat_cnt <= (r_state == S_IDLE) ? C_BEAT_W'(1) : r_beat_cnt + C_BEAT_W'(1);
            if (w_run_enter)
                r_len_left <= len;
            else if (w_feat_fire)
                r_len_left <= r_len_left - LEN_W'(1);
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + C_DRAIN_W'(1) : '0;
        end
    end

    // ---------------- weight shift register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_ROWS; r++)
                for (int c = 0; c < N_COLS; c++)
                    r_w[r][c] <= '0;
        end else if (w_cfg_fire) begin
            for (int r = 0; r < N_ROWS; r++) begin
                r_w[r][0] <= cfg_weight[r*I_WIDTH +: I_WIDTH];
                for (int c = 1; c < N_COLS; c++)
                    r_w[r][c] <= r_w[r][c-1];
            end
        end
    end

    // ---------------- input skew: lane r delayed r extra cycles ----------------
    logic signed [I_WIDTH-1:0] w_skx [N_ROWS];
    logic                      w_skv [N_ROWS];

    for (genvar r = 0; r < N_ROWS; r++) begin : g_skew
        logic signed [I_WIDTH-1:0] r_d  [r+1];
        logic                      r_dv [r+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    r_d[k]  <= '0;
                    r_dv[k] <= 1'b0;
                end
            end else begin
                r_d[0]  <= w_feat_fire ? feat_data[r*I_WIDTH +: I_WIDTH] : '0;
                r_dv[0] <= w_feat_fire;
                for (int k = 1; k <= r; k++) begin
                    r_d[k]  <= r_d[k-1];
                    r_dv[k] <= r_dv[k-1];
                end
            end
        end
        assign w_skx[r] = r_d[r];
        assign w_skv[r] = r_dv[r];
    end

    // ---------------- PE grid ----------------
    logic signed [I_WIDTH-1:0] w_xo  [N_ROWS][N_COLS];
    logic                      w_vo  [N_ROWS][N_COLS];
    logic signed [O_WIDTH-1:0] w_pso [N_ROWS][N_COLS];

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        for (genvar c = 0; c < N_COLS; c++) begin : g_col
            logic signed [I_WIDTH-1:0]   w_xin;
            logic                        w_vin;
            logic signed [O_WIDTH-1:0]   w_psin;
            logic signed [2*I_WIDTH-1:0] w_prod;
            logic signed [I_WIDTH-1:0]   r_x;
            logic                        r_v;
            logic signed [O_WIDTH-1:0]   r_ps;

            if (c == 0) begin : g_edge
                assign w_xin = w_skx[r];
                assign w_vin = w_skv[r];
            end else begin : g_inner
                assign w_xin = w_xo[r][c-1];
                assign w_vin = w_vo[r][c-1];
            end
            if (r == 0) begin : g_top
                assign w_psin = '0;
            end else begin : g_chain
                assign w_psin = w_pso[r-1][c];
            end

            assign w_prod = r_w[r][c] * w_xin;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_x  <= '0;
                    r_v  <= 1'b0;
                    r_ps <= '0;
                end else begin
                    r_x  <= w_xin;
                    r_v  <= w_vin;
                    r_ps <= w_psin + O_WIDTH'(w_prod);
                end
            end
            assign w_xo[r][c]  = r_x;
            assign w_vo[r][c]  = r_v;
            assign w_pso[r][c] = r_ps;
        end
    end

    // ---------------- output deskew: column c delayed N_COLS-1-c ----------------
    logic signed [O_WIDTH-1:0] w_col_sum [N_COLS];
    logic                      w_col_v   [N_COLS];

    for (genvar c = 0; c < N_COLS; c++) begin : g_deskew
        localparam int C_D = N_COLS - 1 - c;
        if (C_D == 0) begin : g_direct
            assign w_col_sum[c] = w_pso[N_ROWS-1][c];
            assign w_col_v[c]   = w_vo[N_ROWS-1][c];
        end else begin : g_delay
            logic signed [O_WIDTH-1:0] r_s  [C_D];
            logic                      r_sv [C_D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < C_D; k++) begin
                        r_s[k]  <= '0;
                        r_sv[k] <= 1'b0;
                    end
                end else begin
                    r_s[0]  <= w_pso[N_ROWS-1][c];
                    r_sv[0] <= w_vo[N_ROWS-1][c];
                    for (int k = 1; k < C_D; k++) begin
                        r_s[k]  <= r_s[k-1];
                        r_sv[k] <= r_sv[k-1];
                    end
                end
            end
            assign w_col_sum[c] = r_s[C_D-1];
            assign w_col_v[c]   = r_sv[C_D-1];
        end
    end

    // ---------------- accumulators ----------------
    logic signed [O_WIDTH-1:0] r_acc     [N_COLS];
    logic signed [O_WIDTH-1:0] w_acc_nxt [N_COLS];

`ifdef SYSTOLIC_ACC_SAT_EN
    localparam logic [O_WIDTH-1:0] C_MAX = {1'b0, {(O_WIDTH-1){1'b1}}};
    localparam logic [O_WIDTH-1:0] C_MIN = {1'b1, {(O_WIDTH-1){1'b0}}};
    logic [O_WIDTH:0]  w_wide [N_COLS];
    logic [N_COLS-1:0] w_clamp;
    logic              r_ovf;

    always_comb begin
        w_clamp = '0;
        for (int c = 0; c < N_COLS; c++) begin
            // One guard bit: top two bits disagree exactly when the add overflowed.
            w_wide[c]    = {r_acc[c][O_WIDTH-1], r_acc[c]} + {w_col_sum[c][O_WIDTH-1], w_col_sum[c]};
            w_acc_nxt[c] = w_wide[c][O_WIDTH-1:0];
            if (w_wide[c][O_WIDTH] != w_wide[c][O_WIDTH-1]) begin
                w_clamp[c]   = w_col_v[c];
                w_acc_nxt[c] = w_wide[c][O_WIDTH] ? C_MIN : C_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_run_enter)
            r_ovf <= 1'b0;
        else if (|w_clamp)
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`else
    always_comb begin
        for (int c = 0; c < N_COLS; c++)
            w_acc_nxt[c] = r_acc[c] + w_col_sum[c];
    end
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_COLS; c++)
                r_acc[c] <= '0;
        end else if (w_run_enter) begin
            for (int c = 0; c < N_COLS; c++)
                r_acc[c] <= '0;
        end else begin
            for (int c = 0; c < N_COLS; c++)
                if (w_col_v[c])
                    r_acc[c] <= w_acc_nxt[c];
        end
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_out
        assign out_data[c*O_WIDTH +: O_WIDTH] = r_acc[c];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_acc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_systolic_array_acc
// Purpose  : Self-checking bench for systolic_array_acc (3x4, O_WIDTH=20).
//            Directed load/accumulate/signed/overflow/backpressure/reset
//            scenarios plus randomized runs against an arithmetic model.
//            Honours SYSTOLIC_ACC_SAT_EN for saturating expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_acc;

    localparam int N   = 3;
    localparam int M   = 4;
    localparam int IW  = 16;
    localparam int OW  = 20;
    localparam int LW  = 16;
    localparam int LAT = N + M;
    localparam longint OMAX = (longint'(1) << (OW-1)) - 1;
    localparam longint OMIN = -(longint'(1) << (OW-1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [N*IW-1:0]   cfg_weight = '0;
    logic              start = 1'b0;
    logic [LW-1:0]     len_i = '0;
    logic              feat_valid = 1'b0;
    logic              feat_ready;
    logic [N*IW-1:0]   feat_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [M*OW-1:0]   out_data;
    logic              busy;
    logic              ovf;

    systolic_array_acc #(
        .N_ROWS(N), .N_COLS(M), .I_WIDTH(IW), .O_WIDTH(OW), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_weight(cfg_weight),
        .start(start), .len(len_i),
        .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [IW-1:0] wm [N][M];
    logic [N*IW-1:0]      fq [$];
    longint               exp_y [M];
    bit                   exp_ovf;

    function automatic logic [N*IW-1:0] vec3(int a, int b, int c);
        logic [N*IW-1:0] v;
        v[0 +: IW]    = IW'(a);
        v[IW +: IW]   = IW'(b);
        v[2*IW +: IW] = IW'(c);
        return v;
    endfunction

    // y[c] = sum_k sum_r w[r][c]*x_k[r], one accumulator update per vector,
    // each update wrapped or clamped to OW signed bits.
    function automatic void model(int n);
        longint acc [M];
        longint s;
        exp_ovf = 1'b0;
        for (int c = 0; c < M; c++) acc[c] = 0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < M; c++) begin
                s = 0;
                for (int r = 0; r < N; r++)
                    s += longint'(wm[r][c]) * longint'($signed(fq[k][r*IW +: IW]));
                acc[c] += s;
`ifdef SYSTOLIC_ACC_SAT_EN
                if (acc[c] > OMAX) begin acc[c] = OMAX; exp_ovf = 1'b1; end
                else if (acc[c] < OMIN) begin acc[c] = OMIN; exp_ovf = 1'b1; end
`else
                acc[c] = acc[c] & ((longint'(1) << OW) - 1);
                if (acc[c] > OMAX) acc[c] -= (longint'(1) << OW);
`endif
            end
        end
        for (int c = 0; c < M; c++) exp_y[c] = acc[c];
    endfunction

    // ---------------- stimulus tasks (begin/end #1 after posedge) ----------------
    task automatic load_w(input int gap_max);
        for (int c = M-1; c >= 0; c--) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            for (int r = 0; r < N; r++) cfg_weight[r*IW +: IW] = wm[r][c];
            cfg_valid = 1'b1;
            @(posedge clk); #1;
            cfg_valid = 1'b0;
        end
    endtask

    task automatic run_job(input int n, input int bub_max, output int lat, output bit to);
        bit ok;
        int g;
        to  = 1'b0;
        lat = -1;
        len_i = LW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, bub_max)) begin @(posedge clk); #1; end
            feat_data  = fq[k];
            feat_valid = 1'b1;
            g = 0;
            do begin
                @(negedge clk); ok = feat_ready;
                @(posedge clk); #1; g++;
            end while (!ok && g < 20);
            if (!ok) to = 1'b1;
            feat_valid = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
            @(posedge clk); #1;
        end
        if (lat < 0) to = 1'b1;
        else begin @(posedge clk); #1; end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic void set_ramp_weights();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                wm[r][c] = IW'(r + c + 1);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++;
        if ({cfg_ready, feat_ready, out_valid, busy, ovf} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl got={cfg_rdy,feat_rdy,oval,busy,ovf}=%b exp=10000",
                     {cfg_ready, feat_ready, out_valid, busy, ovf});
        end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
    endtask

    task automatic test_load();
        int lat; bit to; logic signed [63:0] got;
        set_ramp_weights();
        load_w(2);
        n_cmp++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL load_idle got busy=%b cfg_ready=%b exp 0/1", busy, cfg_ready);
        end
        fq.delete(); fq.push_back(vec3(1, 2, 3));
        run_job(1, 0, lat, to);
        n_cmp++;
        if (to || lat != LAT) begin n_err++; $display("FAIL T1_latency got=%0d (to=%0d) exp=%0d", lat, to, LAT); end
        exp_y = '{14, 20, 26, 32};
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== exp_y[c]) begin n_err++; $display("FAIL T1_y%0d got=%0d exp=%0d", c, got, exp_y[c]); end
        end
        finish_out();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL T1_release got oval=%b busy=%b exp 0/0", out_valid, busy);
        end
    endtask

    task automatic test_accumulate();
        int lat; bit to; logic signed [63:0] got;
        fq.delete();
        repeat (4) fq.push_back(vec3(1, 2, 3));
        run_job(4, 3, lat, to);
        n_cmp++;
        if (to || lat != LAT) begin n_err++; $display("FAIL T2_latency got=%0d (to=%0d) exp=%0d", lat, to, LAT); end
        exp_y = '{56, 80, 104, 128};
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== exp_y[c]) begin n_err++; $display("FAIL T2_y%0d got=%0d exp=%0d", c, got, exp_y[c]); end
        end
        finish_out();
    endtask

    task automatic test_signed();
        int lat; bit to; logic signed [63:0] got;
        for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) wm[r][c] = -16'sd1;
        load_w(0);
        fq.delete(); fq.push_back(vec3(-32768, -32768, -32768));
        run_job(1, 0, lat, to);
        n_cmp++;
        if (to || lat != LAT) begin n_err++; $display("FAIL T3_latency got=%0d (to=%0d) exp=%0d", lat, to, LAT); end
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== 64'sd98304) begin n_err++; $display("FAIL T3_y%0d got=%0d exp=98304", c, got); end
        end
        finish_out();
    endtask

    task automatic test_overflow();
        int lat; bit to; logic signed [63:0] got; longint ey; bit eo;
`ifdef SYSTOLIC_ACC_SAT_EN
        ey = 524287; eo = 1'b1;
`else
        ey = -458752; eo = 1'b0;
`endif
        fq.delete();
        repeat (6) fq.push_back(vec3(-32768, -32768, -32768));
        run_job(6, 1, lat, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL T4_timeout got=none exp=out_valid"); end
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== ey) begin n_err++; $display("FAIL T4_y%0d got=%0d exp=%0d", c, got, ey); end
        end
        n_cmp++;
        if (ovf !== eo) begin n_err++; $display("FAIL T4_ovf got=%b exp=%b", ovf, eo); end
        finish_out();
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic [M*OW-1:0] snap; logic signed [63:0] got;
        set_ramp_weights();
        load_w(1);
        fq.delete(); fq.push_back(vec3(1, 2, 3));
        run_job(1, 0, lat, to);
        snap = out_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin start = 1'b1; len_i = 16'd1; end
            if (i == 5) begin cfg_valid = 1'b1; cfg_weight = {N*IW{1'b1}}; end
            @(negedge clk);
            n_cmp++;
            if (out_data !== snap || {out_valid, feat_ready, cfg_ready, busy} !== 4'b1001) begin
                n_err++;
                $display("FAIL T5_hold cyc=%0d got data=%h oval/frdy/crdy/busy=%b exp data=%h 1001",
                         i, out_data, {out_valid, feat_ready, cfg_ready, busy}, snap);
            end
            @(posedge clk); #1;
            start = 1'b0; cfg_valid = 1'b0;
        end
        finish_out();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL T5_release got oval=%b busy=%b exp 0/0", out_valid, busy);
        end
        // Weights must be untouched by the beat offered while in OUT.
        run_job(1, 0, lat, to);
        exp_y = '{14, 20, 26, 32};
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== exp_y[c]) begin n_err++; $display("FAIL T5_rerun_y%0d got=%0d exp=%0d", c, got, exp_y[c]); end
        end
        finish_out();
    endtask

    task automatic test_len_zero();
        len_i = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || feat_ready !== 1'b0) begin
            n_err++; $display("FAIL len0_dropped got busy=%b feat_ready=%b exp 0/0", busy, feat_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit to; logic signed [63:0] got;
        set_ramp_weights();
        load_w(0);
        len_i = 16'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            feat_data = vec3(1, 2, 3); feat_valid = 1'b1;
            @(posedge clk); #1;
        end
        feat_valid = 1'b0;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy, out_valid, cfg_ready, feat_ready} !== 4'b0010 || out_data !== '0) begin
            n_err++;
            $display("FAIL T6_abort got busy/oval/crdy/frdy=%b data=%h exp 0010 data=0",
                     {busy, out_valid, cfg_ready, feat_ready}, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) wm[r][c] = '0;
        fq.delete(); fq.push_back(vec3(1, 2, 3));
        run_job(1, 0, lat, to);
        n_cmp++;
        if (to || lat != LAT) begin n_err++; $display("FAIL T6_latency got=%0d (to=%0d) exp=%0d", lat, to, LAT); end
        for (int c = 0; c < M; c++) begin
            got = $signed(out_data[c*OW +: OW]);
            n_cmp++;
            if (got !== 64'sd0) begin n_err++; $display("FAIL T6_zero_y%0d got=%0d exp=0", c, got); end
        end
        finish_out();
    endtask

    task automatic test_random();
        int lat; bit to; int n; logic signed [63:0] got;
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < M; c++)
                    wm[r][c] = IW'(int'($urandom_range(0, 400)) - 200);
            load_w(2);
            n = int'($urandom_range(1, 8));
            fq.delete();
            for (int k = 0; k < n; k++)
                fq.push_back(vec3(int'($urandom_range(0, 400)) - 200,
                                  int'($urandom_range(0, 400)) - 200,
                                  int'($urandom_range(0, 400)) - 200));
            model(n);
            run_job(n, 2, lat, to);
            n_cmp++;
            if (to || lat != LAT) begin n_err++; $display("FAIL rnd%0d_latency got=%0d (to=%0d) exp=%0d", it, lat, to, LAT); end
            for (int c = 0; c < M; c++) begin
                got = $signed(out_data[c*OW +: OW]);
                n_cmp++;
                if (got !== exp_y[c]) begin n_err++; $display("FAIL rnd%0d_y%0d got=%0d exp=%0d", it, c, got, exp_y[c]); end
            end
            n_cmp++;
            if (ovf !== exp_ovf) begin n_err++; $display("FAIL rnd%0d_ovf got=%b exp=%b", it, ovf, exp_ovf); end
            finish_out();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_load();
        test_accumulate();
        test_signed();
        test_overflow();
        test_backpressure();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
